// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Imported by the storage array and the FIFO top level.
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port FIFO storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [addr_w(DEPTH)-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [addr_w(DEPTH)-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with thresholds, occupancy count, sticky error flags,
// synchronous flush and selectable standard / first-word-fall-through read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        write_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        read_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [addr_w(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clr
);

    localparam int         AW        = addr_w(DEPTH);
    localparam read_mode_e MODE      = (FWFT != 0) ? MODE_FWFT : MODE_STD;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]           wptr, rptr, cnt;
    logic [AW:0]           wptr_nxt, rptr_nxt, cnt_nxt;
    logic                  full_q, empty_q, ovf_q, udf_q, dv_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data, dout_q;
    fifo_status_t          status;

    // A same-cycle read never frees a slot for the write; full gates it alone.
    assign wr_acc = write_en && !full_q;
    assign rd_acc = read_en && !empty_q;

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            if (wr_acc) wptr_nxt = wptr + 1'b1;
            if (rd_acc) rptr_nxt = rptr + 1'b1;
        end
        cnt_nxt = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            cnt     <= cnt_nxt;
            full_q  <= (cnt_nxt == DEPTH_CNT);
            empty_q <= (cnt_nxt == '0);
        end
    end

    // A fresh error event in the clearing cycle keeps its flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (write_en && full_q) ovf_q <= 1'b1;
            else if (err_clr)       ovf_q <= 1'b0;
            if (read_en && empty_q) udf_q <= 1'b1;
            else if (err_clr)       udf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            dv_q <= rd_acc && !flush && (MODE == MODE_STD);
            if (rd_acc && !flush) dout_q <= rd_data;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !flush),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        status              = '0;
        status.full         = full_q;
        status.empty        = empty_q;
        status.almost_full  = (int'(cnt) >= AFULL_THRESH);
        status.almost_empty = (int'(cnt) <= AEMPTY_THRESH);
        status.overflow     = ovf_q;
        status.underflow    = udf_q;
    end

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = cnt;

    assign data_out   = (MODE == MODE_FWFT) ? (empty_q ? '0 : rd_data) : dout_q;
    assign data_valid = (MODE == MODE_FWFT) ? !empty_q : dv_q;

endmodule
